vga_timing_gen: RTL

Pixel-clock-domain raster generator that sits directly upstream of the on-screen debug overlay. It produces the row/col scan position that the overlay consumes and takes the overlay's 8-bit combinational color back. It drives the board's hsync, vsync and 3:3:3 RGB pins, registered and latency-aligned. The default configuration is 640x480 @ 60 Hz on a 25.175 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster generator: scan position for the overlay, registered sync
// and 3:3:3 RGB pins aligned to the same one-cycle latency.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] color,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       visible,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [2:0] blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_LEN    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_VIS_LAST   = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] H_FRONT_LAST = HW'(H_FRONT - 1);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_SYNC - 1);
    localparam logic [HW-1:0] H_BACK_LAST  = HW'(H_BACK - 1);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LEN    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS_LAST   = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_FRONT_LAST = VW'(V_FRONT - 1);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] V_BACK_LAST  = VW'(V_BACK - 1);

    typedef enum logic [1:0] {
        PH_VIS,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_VIS:   next_phase = PH_FRONT;
            PH_FRONT: next_phase = PH_SYNC;
            PH_SYNC:  next_phase = PH_BACK;
            default:  next_phase = PH_VIS;
        endcase
    endfunction

    logic [HW-1:0] h_cnt, h_cnt_next;
    logic [HW-1:0] h_ph, h_ph_next, h_ph_last;
    phase_t        h_state, h_state_next;
    logic          h_wrap;

    logic [VW-1:0] v_cnt, v_cnt_next;
    logic [VW-1:0] v_ph, v_ph_next, v_ph_last;
    phase_t        v_state, v_state_next;
    logic          v_wrap;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        h_wrap       = (h_cnt == H_LAST);
        h_cnt_next   = h_wrap ? '0 : h_cnt + 1'b1;
        h_state_next = h_state;
        h_ph_next    = h_ph + 1'b1;
        case (h_state)
            PH_VIS:   h_ph_last = H_VIS_LAST;
            PH_FRONT: h_ph_last = H_FRONT_LAST;
            PH_SYNC:  h_ph_last = H_SYNC_LAST;
            default:  h_ph_last = H_BACK_LAST;
        endcase
        if (h_ph == h_ph_last) begin
            h_ph_next    = '0;
            h_state_next = next_phase(h_state);
        end
    end

    // The vertical axis only moves on the horizontal wrap cycle.
    always_comb begin
        v_wrap       = (v_cnt == V_LAST);
        v_cnt_next   = v_cnt;
        v_state_next = v_state;
        v_ph_next    = v_ph;
        case (v_state)
            PH_VIS:   v_ph_last = V_VIS_LAST;
            PH_FRONT: v_ph_last = V_FRONT_LAST;
            PH_SYNC:  v_ph_last = V_SYNC_LAST;
            default:  v_ph_last = V_BACK_LAST;
        endcase
        if (h_wrap) begin
            v_cnt_next = v_wrap ? '0 : v_cnt + 1'b1;
            if (v_ph == v_ph_last) begin
                v_ph_next    = '0;
                v_state_next = next_phase(v_state);
            end else begin
                v_ph_next = v_ph + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h_cnt   <= '0;
            h_ph    <= '0;
            h_state <= PH_VIS;
            v_cnt   <= '0;
            v_ph    <= '0;
            v_state <= PH_VIS;
        end else begin
            h_cnt   <= h_cnt_next;
            h_ph    <= h_ph_next;
            h_state <= h_state_next;
            v_cnt   <= v_cnt_next;
            v_ph    <= v_ph_next;
            v_state <= v_state_next;
        end
    end

    // Stage 0: scan position seen by the overlay in the same cycle.
    always_comb begin
        col         = (h_cnt < H_VIS_LEN) ? 10'(h_cnt) : '0;
        row         = (v_cnt < V_VIS_LEN) ? 10'(v_cnt) : '0;
        visible     = (h_state == PH_VIS) && (v_state == PH_VIS);
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage 1: blanking forces black, so color is never sampled outside the active area.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            if (visible) begin
                red   <= color[7:5];
                green <= color[4:2];
                blue  <= {color[1:0], color[1]};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
            hsync <= (h_state == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= (v_state == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule
